serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to add a/b/cin; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured when start accepted.
REQ-006 b  input  WIDTH  operand B, captured when start accepted.
REQ-007 cin  input  1  carry-in, captured when start accepted.
REQ-008 busy  output  1  high while an addition is in progress (RUN, DRAIN).
REQ-009 done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 sum  output  WIDTH  result, held stable until next accepted start.
REQ-011 cout  output  1  carry-out of bit WIDTH-1, held like sum.

Function
REQ-012 Block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, through one registered 1-bit full-adder cell.
REQ-013 FSM states SHALL be IDLE, RUN, DRAIN, DONE; encoding from the shared package.
REQ-014 IDLE: start=1 at edge k -> capture a, b, cin into shift/holding registers, clear bit counter, enter RUN.
REQ-015 RUN: cycle i (i=0..WIDTH-1) presents a[i], b[i] and carry to the cell; carry = captured cin for i=0, else cell registered carry.
REQ-016 Cell output registered 1 cycle: sum bit i SHALL be shifted into result register at edge k+i+2 (DRAIN covers the last bit).
REQ-017 RUN -> DRAIN when counter reaches WIDTH-1; DRAIN -> DONE after 1 cycle; DONE -> IDLE after 1 cycle.
REQ-018 Latency: done SHALL be high exactly in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles after start sampled; done high for exactly 1 cycle.
REQ-019 sum/cout SHALL update only at DONE entry; intermediate bits held in internal shift register, not visible on sum.
REQ-020 cout SHALL equal cell carry produced by bit WIDTH-1.
REQ-021 start while busy or in DONE SHALL be ignored with no effect on operands or result.
REQ-022 Back-to-back: start asserted in the first IDLE cycle after DONE SHALL be accepted; minimum issue interval WIDTH+3 cycles.
REQ-023 Changes on a/b/cin after capture SHALL NOT affect the in-flight result.
REQ-024 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.

Reset
REQ-025 rst_n low SHALL asynchronously force: state IDLE, busy 0, done 0, sum 0, cout 0, counter 0, cell sum/carry 0, operand registers 0.
REQ-026 Reset mid-operation SHALL abort the addition; no done pulse for it; first edge after release sees IDLE.
REQ-027 start high coincident with reset release edge SHALL be ignored (rst_n sampled low at that edge).

Structure
REQ-028 Package serial_add_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-029 One sub-module fa_bit_cell: inputs clk, rst_n, a, b, c; registered outputs s, co; async active-low reset to 0.
REQ-030 Counter width SHALL be $clog2(WIDTH); no combinational path from inputs to outputs.

Verification
REQ-031 WIDTH=8, a=0x5A, b=0x3C, cin=0, start 1 cycle -> done at start+10 cycles, sum=0x96, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-033 start held high continuously with a/b changing every cycle -> only first operands used; second op accepted first IDLE cycle after DONE, done pulses spaced 11 cycles.
REQ-034 rst_n low at RUN bit 3 -> busy/done/sum/cout 0 immediately; no done; next op 0x01+0x01 -> sum=0x02.
REQ-035 Random 1000 ops, WIDTH=8 and 16 -> {cout,sum} matches reference a+b+cin; done exactly once per accepted start.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e      : controller FSM state type
//   DefaultWidth : default operand/result width in bits
package serial_add_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/fa_bit_cell.sv
// Registered 1-bit full adder cell.
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b, c    : addend bits and carry-in
//   s, co      : registered sum and carry-out (cleared on reset)
module fa_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s  <= 1'b0;
      co <= 1'b0;
    end else begin
      s  <= a ^ b ^ c;
      co <= (a & b) | (a & c) | (b & c);
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: computes {cout,sum} = a + b + cin, LSB first, through one
// registered full-adder cell. Result appears WIDTH+2 cycles after start is accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in idle
//   a, b, cin  : operands, captured when start is accepted
//   busy       : high while running or draining
//   done       : one-cycle pulse when sum/cout are updated
//   sum, cout  : result, held until the next result is produced
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [WIDTH-1:0] res_next;
  logic             cin_q;
  logic [CntW-1:0]  cnt_q;
  logic             cell_c;
  logic             cell_s;
  logic             cell_co;

  // Bit 0 takes the captured carry-in; later bits chain the cell's registered carry.
  assign cell_c   = (cnt_q == '0) ? cin_q : cell_co;
  // Cell output lags one cycle, so the bit shifted in here belongs to the previous RUN cycle.
  assign res_next = {cell_s, res_sh_q[WIDTH-1:1]};

  fa_bit_cell u_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (cell_c),
    .s     (cell_s),
    .co    (cell_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            cin_q   <= cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          if (cnt_q != '0) begin
            res_sh_q <= res_next;
          end
          if (cnt_q == LastCnt) begin
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrain: begin
          // Last sum bit and its carry-out land here; publish the full result.
          res_sh_q <= res_next;
          sum      <= res_next;
          cout     <= cell_co;
          cnt_q    <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int unsigned W8  = 8;
  localparam int unsigned W16 = 16;
  localparam int unsigned NRand = 1000;

  logic clk = 1'b0;
  logic rst_n;

  logic          start8, cin8, busy8, done8, cout8;
  logic [7:0]    a8, b8, sum8;
  logic          start16, cin16, busy16, done16, cout16;
  logic [15:0]   a16, b16, sum16;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] q8[$];
  logic [63:0] q16[$];
  bit          mon_en = 1'b0;
  int          ndone8 = 0;
  int          ndone16 = 0;
  logic [8:0]  prev8;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(W16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .cin   (cin16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards for the random phase: each done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (mon_en && done8) begin
      ndone8++;
      check("rand8_pending", 64'(q8.size() > 0), 64'd1);
      if (q8.size() > 0) check("rand8_result", 64'({cout8, sum8}), q8.pop_front());
    end
    if (mon_en && done16) begin
      ndone16++;
      check("rand16_pending", 64'(q16.size() > 0), 64'd1);
      if (q16.size() > 0) check("rand16_result", 64'({cout16, sum16}), q16.pop_front());
    end
  end

  // One 8-bit op with cycle-accurate checks of busy/done timing and result hold.
  task automatic op8(input string name, input logic [7:0] ia, input logic [7:0] ib,
                     input logic ic, input logic [8:0] exp);
    int done_at = -1;
    int ndone = 0;
    int bad_busy = 0;
    int bad_hold = 0;
    @(negedge clk);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    // Operands changing after capture must not matter.
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int j = 0; j < int'(W8) + 3; j++) begin
      if (j > 0) @(negedge clk);
      if (done8) begin
        ndone++;
        done_at = j;
      end
      if (busy8 !== (j <= int'(W8))) bad_busy++;
      if (j <= int'(W8) && {cout8, sum8} !== prev8) bad_hold++;
    end
    check({name, "_done_at"}, 64'(done_at), 64'(W8 + 1));
    check({name, "_done_cnt"}, 64'(ndone), 64'd1);
    check({name, "_busy"}, 64'(bad_busy), 64'd0);
    check({name, "_hold"}, 64'(bad_hold), 64'd0);
    check({name, "_result"}, 64'({cout8, sum8}), 64'(exp));
    prev8 = exp;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] da[32];
    logic [7:0] db[32];
    logic       dc[32];
    int         d_at[$];
    logic [8:0] d_res[$];
    int         nd;
    logic [8:0] e2;
    bit         got8, got16;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    prev8 = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs8", 64'({busy8, done8, cout8, sum8}), 64'd0);
    check("reset_outputs16", 64'({busy16, done16, cout16, sum16}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op8($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].sum});
    end

    // start held high with operands changing every cycle.
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    for (int j = 0; j < 23; j++) begin
      @(negedge clk);
      if (done8) begin
        d_at.push_back(j);
        d_res.push_back({cout8, sum8});
      end
      da[j] = 8'($urandom); db[j] = 8'($urandom); dc[j] = 1'($urandom);
      a8 = da[j]; b8 = db[j]; cin8 = dc[j];
      if (j >= 20) start8 = 1'b0;
    end
    nd = d_at.size();
    check("hold_start_done_cnt", 64'(nd), 64'd2);
    if (nd == 2) begin
      check("hold_start_first_at", 64'(d_at[0]), 64'(W8 + 1));
      check("hold_start_spacing", 64'(d_at[1] - d_at[0]), 64'(W8 + 3));
      check("hold_start_first_res", 64'(d_res[0]), 64'h33);
      // Second op is accepted W8+3 edges after the first; it sees values driven one cycle before.
      e2 = {1'b0, da[W8 + 2]} + {1'b0, db[W8 + 2]} + 9'(dc[W8 + 2]);
      check("hold_start_second_res", 64'(d_res[1]), 64'(e2));
    end
    prev8 = {cout8, sum8};

    // Reset in the middle of RUN (bit 3).
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'({busy8, done8, cout8, sum8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int j = 0; j < int'(W8) + 4; j++) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    check("midrun_no_done", 64'(nd), 64'd0);
    prev8 = '0;
    op8("after_reset", 8'h01, 8'h01, 1'b0, 9'h002);

    // Random ops on both widths, with ignored start pulses injected while busy.
    mon_en = 1'b1;
    @(negedge clk);
    for (int n = 0; n < int'(NRand); n++) begin
      logic [31:0] ra, rb;
      logic        rc;
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc;
      a16 = ra[15:0]; b16 = rb[15:0]; cin16 = rc;
      start8 = 1'b1; start16 = 1'b1;
      q8.push_back(64'({1'b0, ra[7:0]} + {1'b0, rb[7:0]} + 9'(rc)));
      q16.push_back(64'({1'b0, ra[15:0]} + {1'b0, rb[15:0]} + 17'(rc)));
      @(negedge clk);
      got8 = 1'b0; got16 = 1'b0;
      for (int t = 0; t < 40; t++) begin
        if (done8) got8 = 1'b1;
        if (done16) got16 = 1'b1;
        if (got8 && got16) break;
        start8 = (t >= 1 && t <= 7) ? 1'($urandom) : 1'b0;
        start16 = start8;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        @(negedge clk);
      end
      start8 = 1'b0; start16 = 1'b0;
      check("rand_timeout", 64'({got8, got16}), 64'd3);
      repeat (1 + $urandom_range(0, 1)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("rand8_done_total", 64'(ndone8), 64'(NRand));
    check("rand16_done_total", 64'(ndone16), 64'(NRand));
    check("rand_queues_empty", 64'(q8.size() + q16.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
